gate_op_arbiter: RTL and testbench
==================================

# gate_op_arbiter

Round-robin arbiter and sequencer that time-shares one combinational basic-gate unit among `NREQ` requesters. Each requester presents an opcode (NOT/AND/OR/NAND/NOR/XOR/XNOR) and two operands. The block grants one requester at a time, latches its operands, evaluates them through the shared gate unit, and returns a registered result with the requester ID over a single response channel that supports backpressure. It sits between the client logic and the gate datapath and is the only block that drives the gate unit's inputs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 1: operand/result width; all gate operations are bitwise.
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_op`  in  NREQ*3  packed opcodes; requester i is at [3i+2:3i].
- `req_a`  in  NREQ*W  packed operand A; requester i is at [W*i+W-1:W*i].
- `req_b`  in  NREQ*W  packed operand B, same packing as `req_a`; ignored for NOT.
- `req_ready`  out  NREQ  one-hot or zero; acceptance occurs when `req_valid[i] & req_ready[i]` at a clock edge.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  clog2(NREQ)  index of the requester being answered.
- `rsp_data`  out  W  result.
- `rsp_err`  out  1  high when the opcode was illegal.
- `busy`  out  1  high in the EXEC and RESP states.
- `op_count`  out  CNT_W  number of completed responses; wraps modulo 2^CNT_W.

## Operation
- Opcode encoding: 0 NOT(a), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal.
- FSM states:
  - IDLE:
    - `req_ready[g]` is driven high combinationally for winner g. The winner is the first requester with `req_valid` set, scanning from `rr_ptr` upward and wrapping at NREQ.
    - On acceptance, latch op/a/b and g, then go to EXEC.
    - With no valid request, stay in IDLE.
  - EXEC:
    - The latched operands drive the `gate_unit`. The output selected by the latched op is registered into `rsp_data`.
    - For op 7, `rsp_data`=0 and `rsp_err`=1.
    - Go to RESP unconditionally.
  - RESP:
    - `rsp_valid`=1; `rsp_id`/`rsp_data`/`rsp_err` are held stable.
    - On `rsp_ready`: `rr_ptr` ← (g+1) mod NREQ, `op_count`++, state → IDLE.
    - Otherwise hold indefinitely.
- `req_ready` is 0 in every state other than IDLE.
- Requests from non-granted requesters are not consumed; they wait.
- `rr_ptr` advances only on response completion, never on acceptance.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `op_count`=0.
- Latency: with acceptance at edge e0, `rsp_valid` rises after edge e0+1 (EXEC at e0→e0+1).
- Throughput: with `rsp_ready` held high, the minimum spacing between acceptances is 3 cycles (accept, EXEC, RESP handshake; next accept at e0+3).
- Multiple simultaneous `req_valid`: exactly one grant, per the round-robin order.
- A `req_valid` deasserted before acceptance is legal and no grant is recorded.
- `rsp_ready` high while `rsp_valid` is low has no effect.
- `op_count` wraps from 2^CNT_W−1 to 0 without error.
- `rst_n` asserted mid-operation (EXEC or RESP):
  - All state returns immediately to reset values.
  - The in-flight transaction is dropped and no response is produced.
  - After release, the first grant starts from requester 0.
- The NREQ=2 wrap: a pointer value of 1 followed by completion gives a pointer of 0.

## Structure
- Shared package `gate_pkg` holds:
  - the opcode localparams `OP_NOT`..`OP_XNOR` and `OP_ILL`;
  - the opcode typedef (3 bits);
  - the gate output index constants matching output order [0:6] = not, and, or, nand, nor, xor, xnor.
- Sub-module `gate_unit`:
  - W-bit combinational block;
  - inputs a, b; output `out[0:6]` in the order above;
  - instantiated exactly once.
- The round-robin winner search is a combinational function inside `gate_op_arbiter`.

## Test plan
- Reset/idle: after reset release with no requests for 10 cycles → all outputs hold their reset values and `req_ready`=0.
- Single op sweep, W=1, requester 2: each op 0..6 applied with all four {a,b} combinations → `rsp_data` matches the gate truth table (e.g. op5, a=1, b=1 → 0), `rsp_id`=2, `rsp_err`=0, `rsp_valid` one edge after acceptance.
- Fairness, NREQ=4: all four `req_valid` held high with `rsp_ready`=1 for 8 transactions → grant order 0,1,2,3,0,1,2,3, with a 3-cycle spacing and `op_count`=8.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`/`rsp_data` stable, `req_ready` all 0; the completion edge after `rsp_ready` goes high increments `op_count` by 1.
- Illegal op 7 with a=1, b=1 → `rsp_data`=0, `rsp_err`=1, and `op_count` still increments.
- Reset mid-op: `rst_n` pulsed low during RESP → `rsp_valid` drops asynchronously, no completion is counted, and the next grant with all requests valid goes to requester 0.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared opcode, gate-output index and FSM definitions for the gate arbiter slice.
package gate_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOT  = 3'd0;
  localparam op_t OP_AND  = 3'd1;
  localparam op_t OP_OR   = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XOR  = 3'd5;
  localparam op_t OP_XNOR = 3'd6;
  localparam op_t OP_ILL  = 3'd7;

  localparam int G_NOT     = 0;
  localparam int G_AND     = 1;
  localparam int G_OR      = 2;
  localparam int G_NAND    = 3;
  localparam int G_NOR     = 4;
  localparam int G_XOR     = 5;
  localparam int G_XNOR    = 6;
  localparam int NUM_GATES = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gate_unit.sv
// Combinational bitwise gate bank; every gate result is produced in parallel and
// the caller selects one by output index.
module gate_unit
  import gate_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out [0:NUM_GATES-1]
);

  assign out[G_NOT]  = ~a;
  assign out[G_AND]  = a & b;
  assign out[G_OR]   = a | b;
  assign out[G_NAND] = ~(a & b);
  assign out[G_NOR]  = ~(a | b);
  assign out[G_XOR]  = a ^ b;
  assign out[G_XNOR] = ~(a ^ b);

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter that time-shares one gate_unit among NREQ requesters and
// returns one registered result at a time over a backpressured response channel.
module gate_op_arbiter
  import gate_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = 1,
  parameter int CNT_W = 16,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*3-1:0] req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  // Returns {found, index}: first valid requester scanning up from ptr with wrap.
  function automatic logic [ID_W:0] find_winner(input logic [NREQ-1:0] valid,
                                                input logic [ID_W-1:0] ptr);
    logic [ID_W:0] res;
    int idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  state_t          state, next_state;
  logic [ID_W-1:0] rr_ptr;
  op_t             lat_op;
  logic [W-1:0]    lat_a, lat_b;
  logic [ID_W:0]   win;
  logic [ID_W-1:0] win_id;
  logic            accept;
  logic [W-1:0]    result;
  logic [W-1:0]    gate_out [0:NUM_GATES-1];

  assign win    = find_winner(req_valid, rr_ptr);
  assign win_id = win[ID_W-1:0];

  gate_unit #(.W(W)) u_gate (
    .a   (lat_a),
    .b   (lat_b),
    .out (gate_out)
  );

  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win[ID_W]) begin
          req_ready[win_id] = 1'b1;
          accept            = 1'b1;
          next_state        = ST_EXEC;
        end
      end
      ST_EXEC: next_state = ST_RESP;
      ST_RESP: if (rsp_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    case (lat_op)
      OP_NOT:  result = gate_out[G_NOT];
      OP_AND:  result = gate_out[G_AND];
      OP_OR:   result = gate_out[G_OR];
      OP_NAND: result = gate_out[G_NAND];
      OP_NOR:  result = gate_out[G_NOR];
      OP_XOR:  result = gate_out[G_XOR];
      OP_XNOR: result = gate_out[G_XNOR];
      default: result = '0;
    endcase
  end

  // The pointer moves only on response completion so a stalled response keeps priority fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      lat_op   <= OP_NOT;
      lat_a    <= '0;
      lat_b    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      op_count <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_op <= req_op[3*int'(win_id) +: 3];
            lat_a  <= req_a[W*int'(win_id) +: W];
            lat_b  <= req_b[W*int'(win_id) +: W];
            rsp_id <= win_id;
          end
        end
        ST_EXEC: begin
          rsp_data <= result;
          rsp_err  <= (lat_op == OP_ILL);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rr_ptr   <= (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + ID_W'(1);
            op_count <= op_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench for gate_op_arbiter: truth-table vectors, fairness, backpressure,
// reset-in-flight and randomized transactions against a behavioural model.
module tb_gate_op_arbiter;
  import gate_pkg::*;

  localparam int NREQ  = 4;
  localparam int W     = 4;
  localparam int CNT_W = 4;
  localparam int ID_W  = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*3-1:0] req_op = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  always #5 clk = ~clk;

  gate_op_arbiter #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  int           n_checks = 0;
  int           n_pass = 0;
  int           model_ptr = 0;
  int           model_count = 0;
  logic [2:0]   op_arr [NREQ];
  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_gate(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3] = op_arr[i];
      req_a[W*i +: W]  = a_arr[i];
      req_b[W*i +: W]  = b_arr[i];
    end
  endtask

  task automatic randomize_requesters();
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = 3'($urandom_range(0, 7));
      a_arr[i]  = W'($urandom);
      b_arr[i]  = W'($urandom);
    end
  endtask

  // One full transaction from IDLE: offer mask, check grant, EXEC, RESP held for 'hold' cycles, completion.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int hold,
                               output int got_id, output logic [W-1:0] got_data, output logic got_err);
    int w;
    logic [W-1:0] exp_data;
    logic exp_err;
    got_id = -1;
    got_data = '0;
    got_err = 1'b0;
    @(negedge clk);
    pack_inputs();
    req_valid = mask;
    rsp_ready = 1'b0;
    #1;
    w = model_winner(mask, model_ptr);
    if (w < 0) begin
      checkOutput("no_req_ready", req_ready, 0);
      @(negedge clk);
      checkOutput("no_req_busy", busy, 0);
      return;
    end
    checkOutput("grant_onehot", req_ready, 32'(1) << w);
    exp_data = model_gate(op_arr[w], a_arr[w], b_arr[w]);
    exp_err  = (op_arr[w] == 3'd7);
    @(negedge clk);
    req_valid = '0;
    checkOutput("exec_busy", busy, 1);
    checkOutput("exec_rsp_valid", rsp_valid, 0);
    checkOutput("exec_req_ready", req_ready, 0);
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      checkOutput("resp_valid", rsp_valid, 1);
      checkOutput("resp_id", rsp_id, w);
      checkOutput("resp_data", rsp_data, exp_data);
      checkOutput("resp_err", rsp_err, exp_err);
      checkOutput("resp_req_ready", req_ready, 0);
      checkOutput("resp_count_hold", op_count, model_count);
      if (h < hold) @(negedge clk);
    end
    got_id = int'(rsp_id);
    got_data = rsp_data;
    got_err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_count = (model_count + 1) % (1 << CNT_W);
    model_ptr = (w + 1) % NREQ;
    checkOutput("done_rsp_valid", rsp_valid, 0);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_op_count", op_count, model_count);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [8];
    int gid, last_cyc, grants, cyc, wid;
    logic [W-1:0] gdata;
    logic gerr;

    // a=1100, b=1010 covers all four {a,b} bit combinations in one vector
    tbl[0] = '{3'd0, 4'b1100, 4'b1010, 4'b0011, 1'b0};
    tbl[1] = '{3'd1, 4'b1100, 4'b1010, 4'b1000, 1'b0};
    tbl[2] = '{3'd2, 4'b1100, 4'b1010, 4'b1110, 1'b0};
    tbl[3] = '{3'd3, 4'b1100, 4'b1010, 4'b0111, 1'b0};
    tbl[4] = '{3'd4, 4'b1100, 4'b1010, 4'b0001, 1'b0};
    tbl[5] = '{3'd5, 4'b1100, 4'b1010, 4'b0110, 1'b0};
    tbl[6] = '{3'd6, 4'b1100, 4'b1010, 4'b1001, 1'b0};
    tbl[7] = '{3'd7, 4'b1111, 4'b1111, 4'b0000, 1'b1};

    randomize_requesters();
    pack_inputs();
    #12;
    checkOutput("in_reset_rsp_valid", rsp_valid, 0);
    checkOutput("in_reset_op_count", op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle_req_ready", req_ready, 0);
      checkOutput("idle_rsp_valid", rsp_valid, 0);
      checkOutput("idle_rsp_id", rsp_id, 0);
      checkOutput("idle_rsp_data", rsp_data, 0);
      checkOutput("idle_rsp_err", rsp_err, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_op_count", op_count, 0);
    end

    $display("[TB] fairness with all requesters valid");
    randomize_requesters();
    pack_inputs();
    @(negedge clk);
    req_valid = '1;
    rsp_ready = 1'b1;
    grants = 0;
    last_cyc = 0;
    cyc = 0;
    gid = 0;
    while (grants < 8 && cyc < 60) begin
      #1;
      if ((req_valid & req_ready) != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        checkOutput("fair_order", gid, grants % NREQ);
        if (grants > 0) checkOutput("fair_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    if (grants < 8) checkOutput("fair_timeout", grants, 8);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    model_count = 8;
    model_ptr = (gid + 1) % NREQ;
    checkOutput("fair_op_count", op_count, 8);
    checkOutput("fair_busy", busy, 0);

    $display("[TB] truth-table sweep on requester 2");
    for (int t = 0; t < 8; t++) begin
      randomize_requesters();
      op_arr[2] = tbl[t].op;
      a_arr[2]  = tbl[t].a;
      b_arr[2]  = tbl[t].b;
      applyStimulus(4'b0100, 0, wid, gdata, gerr);
      checkOutput("tbl_id", wid, 2);
      checkOutput("tbl_data", gdata, tbl[t].exp_data);
      checkOutput("tbl_err", gerr, tbl[t].exp_err);
    end

    $display("[TB] backpressure hold");
    randomize_requesters();
    applyStimulus(4'b1010, 5, wid, gdata, gerr);

    $display("[TB] rsp_ready while idle, dropped request");
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_ready_count", op_count, model_count);
    checkOutput("idle_ready_valid", rsp_valid, 0);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    checkOutput("drop_offer_ready", req_ready, 4'b0100);
    #2;
    req_valid = '0;
    @(negedge clk);
    checkOutput("drop_busy", busy, 0);
    checkOutput("drop_count", op_count, model_count);

    $display("[TB] randomized transactions");
    for (int r = 0; r < 40; r++) begin
      randomize_requesters();
      applyStimulus(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3), wid, gdata, gerr);
    end

    $display("[TB] reset during RESP");
    randomize_requesters();
    applyStimulus(4'b0010, 0, wid, gdata, gerr);
    @(negedge clk);
    req_valid = '1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checkOutput("pre_reset_valid", rsp_valid, 1);
    checkOutput("pre_reset_id", rsp_id, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_op_count", op_count, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    model_count = 0;
    applyStimulus(4'b1111, 0, wid, gdata, gerr);
    checkOutput("post_reset_grant", wid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
